// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one UART transmitter among four byte requesters
// Optional feature macro: UART_ARB_TIMEOUT_EN (abort a stalled transfer after TIMEOUT_CYCLES WAIT cycles)

module uart_tx_arbiter #(
    parameter int TIMEOUT_CYCLES = 200000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  req,
    input  logic [31:0] reqData,
    output logic [3:0]  gnt,
    output logic [3:0]  done,
    output logic        start,
    output logic [7:0]  txIn,
    input  logic        txDone,
    output logic        busy,
    output logic [1:0]  owner,
    output logic        timeoutErr
);

    typedef enum logic [1:0] {
        IDLE,
        START,
        WAIT,
        COMPLETE
    } state_t;

    state_t     state;
    logic [1:0] lastOwner;
    logic       txDonePrev;
    logic       txDoneRise;
    logic [1:0] winner;
    logic       winnerFound;
    logic [1:0] candidate;

`ifdef UART_ARB_TIMEOUT_EN
    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    logic [CW-1:0] waitCount;
`else
    logic unusedTimeoutCfg;
    assign unusedTimeoutCfg = (TIMEOUT_CYCLES > 0);
    assign timeoutErr = 1'b0;
`endif

    // Only a fresh low-to-high transition of txDone counts as completion,
    // so a level left high from a previous byte cannot finish the next one.
    assign txDoneRise = txDone & ~txDonePrev;

    // Round-robin search starting just after the last served requester;
    // the fourth candidate wraps back to lastOwner itself.
    always_comb begin
        winner      = lastOwner;
        winnerFound = 1'b0;
        candidate   = lastOwner;
        for (int k = 1; k <= 4; k++) begin
            candidate = lastOwner + 2'(k);
            if (!winnerFound && req[candidate]) begin
                winner      = candidate;
                winnerFound = 1'b1;
            end
        end
    end

    // Transfer sequencer: grant, start pulse, wait for completion, done pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            gnt        <= 4'b0000;
            done       <= 4'b0000;
            start      <= 1'b0;
            txIn       <= 8'h00;
            owner      <= 2'd0;
            busy       <= 1'b0;
            lastOwner  <= 2'd3;
            txDonePrev <= 1'b0;
`ifdef UART_ARB_TIMEOUT_EN
            timeoutErr <= 1'b0;
            waitCount  <= '0;
`endif
        end else begin
            txDonePrev <= txDone;
            gnt        <= 4'b0000;
            done       <= 4'b0000;
            start      <= 1'b0;
            case (state)
                IDLE: begin
                    if (|req) begin
                        gnt   <= 4'b0001 << winner;
                        txIn  <= reqData[{winner, 3'b000} +: 8];
                        owner <= winner;
                        busy  <= 1'b1;
                        state <= START;
                    end
                end
                START: begin
                    start <= 1'b1;
                    state <= WAIT;
`ifdef UART_ARB_TIMEOUT_EN
                    waitCount <= '0;
`endif
                end
                WAIT: begin
                    if (txDoneRise) begin
                        done  <= 4'b0001 << owner;
                        state <= COMPLETE;
                    end
`ifdef UART_ARB_TIMEOUT_EN
                    else if (waitCount == TIMEOUT_LAST) begin
                        timeoutErr <= 1'b1;
                        lastOwner  <= owner;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end else begin
                        waitCount <= waitCount + 1'b1;
                    end
`endif
                end
                COMPLETE: begin
                    lastOwner <= owner;
                    busy      <= 1'b0;
                    state     <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - table-driven and scoreboard bench for uart_tx_arbiter

module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] reqData;
    logic [3:0]  gnt;
    logic [3:0]  done;
    logic        start;
    logic [7:0]  txIn;
    logic        txDone;
    logic        busy;
    logic [1:0]  owner;
    logic        timeoutErr;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] gntExp;
        logic [7:0] dataByte;
    } sb_t;

    sb_t sb[$];
    sb_t cur;

    typedef struct {
        logic [3:0]  reqV;
        logic [31:0] dataV;
        int          delay;
        logic [3:0]  expGnt;
        logic [7:0]  expByte;
    } vec_t;

    vec_t vecs[11];

    uart_tx_arbiter #(.TIMEOUT_CYCLES(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .reqData    (reqData),
        .gnt        (gnt),
        .done       (done),
        .start      (start),
        .txIn       (txIn),
        .txDone     (txDone),
        .busy       (busy),
        .owner      (owner),
        .timeoutErr (timeoutErr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExp(input logic [3:0] g, input logic [7:0] b);
        sb_t e;
        e.gntExp   = g;
        e.dataByte = b;
        sb.push_back(e);
    endtask

    // One complete transfer with exact cycle-by-cycle latency checks.
    task automatic doXfer(input logic [3:0] r, input logic [31:0] d, input int delay,
                          input logic [3:0] expGnt, input logic [7:0] expByte);
        pushExp(expGnt, expByte);
        req     = r;
        reqData = d;
        step();
        chk("gnt_latency", gnt, expGnt);
        chk("busy_granted", busy, 1);
        reqData = ~d;
        step();
        chk("start_latency", start, 1);
        chk("txIn_byte", txIn, expByte);
        chk("gnt_cleared", gnt, 0);
        for (int i = 0; i < delay; i++) begin
            step();
            chk("done_early", done, 0);
            chk("txIn_stable", txIn, expByte);
        end
        txDone = 1'b1;
        step();
        chk("done_pulse", done, expGnt);
        txDone = 1'b0;
        step();
        chk("done_one_cycle", done, 0);
        chk("busy_idle", busy, 0);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (!rst) begin
            if (gnt != 4'b0000) begin
                chk("gnt_onehot", {31'b0, $onehot(gnt)}, 1);
                chk("gnt_start_excl", {31'b0, start}, 0);
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected_gnt actual=%0h expected=none", gnt);
                end else begin
                    cur = sb.pop_front();
                    chk("sb_gnt", {28'b0, gnt}, {28'b0, cur.gntExp});
                end
            end
            if (start) chk("sb_txIn", {24'b0, txIn}, {24'b0, cur.dataByte});
            if (done != 4'b0000) chk("sb_done", {28'b0, done}, {28'b0, cur.gntExp});
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        vecs[0]  = '{4'b0001, 32'h000000A5, 0, 4'b0001, 8'hA5};
        vecs[1]  = '{4'b1111, 32'h44332211, 1, 4'b0010, 8'h22};
        vecs[2]  = '{4'b1111, 32'h44332211, 2, 4'b0100, 8'h33};
        vecs[3]  = '{4'b1111, 32'h44332211, 0, 4'b1000, 8'h44};
        vecs[4]  = '{4'b1111, 32'h44332211, 3, 4'b0001, 8'h11};
        vecs[5]  = '{4'b1111, 32'h44332211, 1, 4'b0010, 8'h22};
        vecs[6]  = '{4'b0101, 32'h00C3005A, 0, 4'b0100, 8'hC3};
        vecs[7]  = '{4'b0101, 32'h00C3005A, 2, 4'b0001, 8'h5A};
        vecs[8]  = '{4'b0101, 32'h00C3005A, 1, 4'b0100, 8'hC3};
        vecs[9]  = '{4'b1000, 32'h7E000000, 4, 4'b1000, 8'h7E};
        vecs[10] = '{4'b0110, 32'h00BBCC00, 0, 4'b0010, 8'hCC};

        rst     = 1'b1;
        req     = 4'b0000;
        reqData = 32'h0;
        txDone  = 1'b0;
        repeat (3) step();
        chk("rst_gnt", gnt, 0);
        chk("rst_done", done, 0);
        chk("rst_start", start, 0);
        chk("rst_txIn", txIn, 0);
        chk("rst_owner", owner, 0);
        chk("rst_busy", busy, 0);
        chk("rst_timeoutErr", timeoutErr, 0);
        rst = 1'b0;
        step();
        chk("idle_no_req_gnt", gnt, 0);

        for (int v = 0; v < 11; v++)
            doXfer(vecs[v].reqV, vecs[v].dataV, vecs[v].delay, vecs[v].expGnt, vecs[v].expByte);
        req = 4'b0000;
        step();

        // txDone already high on entry to WAIT must not complete the byte.
        pushExp(4'b0001, 8'h3C);
        req     = 4'b0001;
        reqData = 32'h0000003C;
        txDone  = 1'b1;
        step();
        chk("hi_gnt", gnt, 4'b0001);
        step();
        chk("hi_start", start, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hi_held_no_done", done, 0);
        end
        txDone = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hi_low_no_done", done, 0);
        end
        txDone = 1'b1;
        step();
        chk("hi_new_edge_done", done, 4'b0001);
        txDone = 1'b0;
        req    = 4'b0000;
        step();

        // Reset during WAIT for requester 1 abandons the transfer.
        pushExp(4'b0010, 8'h99);
        req     = 4'b0010;
        reqData = 32'h00009900;
        step();
        chk("rw_gnt", gnt, 4'b0010);
        step();
        step();
        step();
        chk("rw_busy_wait", busy, 1);
        rst     = 1'b1;
        req     = 4'b1010;
        reqData = 32'h66008800;
        txDone  = 1'b1;
        step();
        chk("rw_gnt0", gnt, 0);
        chk("rw_done0", done, 0);
        chk("rw_start0", start, 0);
        chk("rw_txIn0", txIn, 0);
        chk("rw_owner0", owner, 0);
        chk("rw_busy0", busy, 0);
        rst    = 1'b0;
        txDone = 1'b0;
        doXfer(4'b1010, 32'h66008800, 1, 4'b0010, 8'h88);
        req = 4'b0000;
        step();

        // Stalled transmitter: abort with timeout feature, wait indefinitely without.
        pushExp(4'b0001, 8'h17);
        req     = 4'b0001;
        reqData = 32'h00000017;
        step();
        chk("to_gnt", gnt, 4'b0001);
        step();
        chk("to_start", start, 1);
        for (int i = 0; i < 15; i++) begin
            step();
            chk("to_busy_waiting", busy, 1);
            chk("to_err_low", timeoutErr, 0);
        end
`ifdef UART_ARB_TIMEOUT_EN
        step();
        chk("to_err_set", timeoutErr, 1);
        chk("to_busy_cleared", busy, 0);
        chk("to_no_done", done, 0);
`else
        for (int i = 0; i < 10; i++) begin
            step();
            chk("to_still_waiting", busy, 1);
            chk("to_err_tied", timeoutErr, 0);
            chk("to_no_done", done, 0);
        end
        txDone = 1'b1;
        step();
        chk("to_late_done", done, 4'b0001);
        txDone = 1'b0;
        step();
`endif
        doXfer(4'b0101, 32'h00E10017, 0, 4'b0100, 8'hE1);
`ifdef UART_ARB_TIMEOUT_EN
        chk("to_err_sticky", timeoutErr, 1);
`else
        chk("to_err_tied_end", timeoutErr, 0);
`endif
        req = 4'b0000;
        repeat (3) step();
        chk("sb_empty", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
